// File: rtl/daq_pkg.sv
// ---------------------------------------------------------------------------
// daq_pkg
//  Shared constants for the DAQ frame path: default sync bytes, serializer
//  FSM state encoding and frame-length helpers.
// ---------------------------------------------------------------------------
package daq_pkg;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    // Sync x2, sequence, config
    localparam int FRAME_HDR_BYTES = 4;

    // Serializer states (legacy-compatible encoded constants)
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_SEQ  = 3'd3;
    localparam logic [2:0] ST_CFG  = 3'd4;
    localparam logic [2:0] ST_DATA = 3'd5;
    localparam logic [2:0] ST_CSUM = 3'd6;

    // Header + two bytes per channel word + checksum
    function automatic int frame_len(input int adccount);
        return FRAME_HDR_BYTES + 2 * adccount + 1;
    endfunction

endpackage

// File: rtl/daq_sample_capture.sv
// ---------------------------------------------------------------------------
// daq_sample_capture
//  Collects one burst of ADCCOUNT channel words. A word flagged first always
//  restarts the burst at slot 0; a restart mid-burst discards the partial
//  burst and pulses resync_o on the following cycle.
// Ports
//  clk_i, reset_i    clock, asynchronous active-high reset
//  en_i              capture enable (low freezes the slot index)
//  sample_valid_i    word strobe
//  sample_first_i    word is channel 0
//  sample_data_i     channel word
//  words_o           full burst; valid only while done_o is high (last slot
//                    is taken straight from sample_data_i)
//  done_o            high on the edge that accepts the last slot
//  resync_o          1-cycle pulse after a mid-burst restart
// ---------------------------------------------------------------------------
module daq_sample_capture
    import daq_pkg::*;
#(
    parameter int ADCCOUNT = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic                     sample_valid_i,
    input  logic                     sample_first_i,
    input  logic [15:0]              sample_data_i,
    output logic [ADCCOUNT-1:0][15:0] words_o,
    output logic                     done_o,
    output logic                     resync_o
);

    localparam int               IDX_W    = $clog2(ADCCOUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADCCOUNT - 1);

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     resync_q, resync_d;
    logic [ADCCOUNT-2:0][15:0] buf_q;
    logic                     accept_first, accept_next;

    assign accept_first = en_i & sample_valid_i & sample_first_i;
    assign accept_next  = en_i & sample_valid_i & ~sample_first_i & (idx_q != '0);
    assign done_o       = accept_next & (idx_q == LAST_IDX);

    // Last slot never needs storage: hand-off happens on the edge it arrives.
    assign words_o  = {sample_data_i, buf_q};
    assign resync_o = resync_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        idx_d    = idx_q;
        resync_d = 1'b0;
        if (accept_first) begin
            idx_d    = IDX_W'(1);
            resync_d = (idx_q != '0);
        end else if (accept_next) begin
            idx_d = done_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset_i) begin
            idx_q    <= '0;
            resync_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            resync_q <= resync_d;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; it is only read
    // after every slot has been rewritten, and leaving it out of reset keeps
    // it plain storage.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < ADCCOUNT - 1; s++) begin
            if ((accept_first && s == 0) ||
                (accept_next && idx_q == IDX_W'(s)))
                buf_q[s] <= sample_data_i;
        end
    end

endmodule

// File: rtl/daq_frame_serializer.sv
// ---------------------------------------------------------------------------
// daq_frame_serializer
//  Wraps each completed burst in a frame (SYNC0 SYNC1 SEQ CFG DATA.. CSUM)
//  and writes it byte-wide into an 8-bit FIFO. A new burst is captured while
//  the previous frame drains; bursts completing while busy are dropped and
//  counted. The sequence number advances on every completed burst.
// Ports
//  clk_i, reset_i    clock, asynchronous active-high reset
//  en_i              capture enable
//  os_sel_i          oversampling select, stamped into CFG at hand-off
//  sample_*_i        channel word stream from the readout stage
//  fifo_wrfull_i     FIFO full; stalls the serializer with byte held
//  fifo_wrreq_o      FIFO write request (busy and not full)
//  fifo_data_o       current frame byte (00 when idle)
//  busy_o            serializer not idle
//  frame_done_o      high while the checksum byte is being written
//  resync_o          mid-burst restart pulse
//  drop_cnt_o        saturating dropped-burst count
// ---------------------------------------------------------------------------
module daq_frame_serializer
    import daq_pkg::*;
#(
    parameter int         ADCCOUNT = 8,
    parameter logic [7:0] SYNC0    = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1    = SYNC1_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic [2:0]  os_sel_i,
    input  logic        sample_valid_i,
    input  logic        sample_first_i,
    input  logic [15:0] sample_data_i,
    input  logic        fifo_wrfull_i,
    output logic        fifo_wrreq_o,
    output logic [7:0]  fifo_data_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        resync_o,
    output logic [7:0]  drop_cnt_o
);

    localparam int                DATA_BYTES = frame_len(ADCCOUNT) - FRAME_HDR_BYTES - 1;
    localparam int                BIDX_W     = $clog2(DATA_BYTES);
    localparam logic [BIDX_W-1:0] LAST_BIDX  = BIDX_W'(DATA_BYTES - 1);

    logic [ADCCOUNT-1:0][15:0] burst_words;
    logic                      burst_done;

    logic [2:0]                state_q, state_d;
    logic [BIDX_W-1:0]         bidx_q, bidx_d;
    logic [7:0]                seq_q, seq_d;
    logic [7:0]                tx_seq_q, tx_seq_d;
    logic [2:0]                tx_os_q, tx_os_d;
    logic [7:0]                csum_q, csum_d;
    logic [7:0]                drop_q, drop_d;
    logic [ADCCOUNT-1:0][15:0] tx_buf_q;

    logic                      wr, handoff;
    logic [15:0]               cur_word;
    logic [7:0]                cur_byte;

    daq_sample_capture #(.ADCCOUNT(ADCCOUNT)) u_capture (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .en_i           (en_i),
        .sample_valid_i (sample_valid_i),
        .sample_first_i (sample_first_i),
        .sample_data_i  (sample_data_i),
        .words_o        (burst_words),
        .done_o         (burst_done),
        .resync_o       (resync_o)
    );

    assign busy_o       = (state_q != ST_IDLE);
    assign wr           = busy_o & ~fifo_wrfull_i;
    assign fifo_wrreq_o = wr;
    assign fifo_data_o  = cur_byte;
    assign frame_done_o = (state_q == ST_CSUM) & wr;
    assign drop_cnt_o   = drop_q;

    // A burst can be taken when idle, or back-to-back when the checksum of
    // the current frame leaves on this very edge.
    assign handoff = burst_done & ((state_q == ST_IDLE) | ((state_q == ST_CSUM) & wr));

    // Byte index bit 0 selects low byte; upper bits select the channel word.
    assign cur_word = tx_buf_q[bidx_q[BIDX_W-1:1]];

    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            ST_HDR0: cur_byte = SYNC0;
            ST_HDR1: cur_byte = SYNC1;
            ST_SEQ:  cur_byte = tx_seq_q;
            ST_CFG:  cur_byte = {5'b0, tx_os_q};
            ST_DATA: cur_byte = bidx_q[0] ? cur_word[7:0] : cur_word[15:8];
            ST_CSUM: cur_byte = csum_q;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        bidx_d   = bidx_q;
        seq_d    = seq_q;
        tx_seq_d = tx_seq_q;
        tx_os_d  = tx_os_q;
        csum_d   = csum_q;
        drop_d   = drop_q;

        if (wr) begin
            case (state_q)
                ST_HDR0: state_d = ST_HDR1;
                ST_HDR1: state_d = ST_SEQ;
                ST_SEQ: begin
                    state_d = ST_CFG;
                    csum_d  = csum_q + cur_byte;
                end
                ST_CFG: begin
                    state_d = ST_DATA;
                    bidx_d  = '0;
                    csum_d  = csum_q + cur_byte;
                end
                ST_DATA: begin
                    csum_d = csum_q + cur_byte;
                    if (bidx_q == LAST_BIDX) state_d = ST_CSUM;
                    else                     bidx_d  = bidx_q + 1'b1;
                end
                ST_CSUM: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        if (burst_done) seq_d = seq_q + 8'd1;

        if (handoff) begin
            state_d  = ST_HDR0;
            tx_seq_d = seq_q;
            tx_os_d  = os_sel_i;
            csum_d   = 8'h00;
        end else if (burst_done && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            bidx_q   <= '0;
            seq_q    <= 8'h00;
            tx_seq_q <= 8'h00;
            tx_os_q  <= 3'b000;
            csum_q   <= 8'h00;
            drop_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            bidx_q   <= bidx_d;
            seq_q    <= seq_d;
            tx_seq_q <= tx_seq_d;
            tx_os_q  <= tx_os_d;
            csum_q   <= csum_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (handoff) tx_buf_q <= burst_words;
    end

endmodule

// File: tb/tb_daq_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_daq_frame_serializer
//  Directed bench for daq_frame_serializer (ADCCOUNT = 8). Inputs change 1ns
//  after the rising edge; outputs are sampled on the falling edge. A monitor
//  records every byte written to the FIFO; frames are compared against
//  expected byte lists built from the burst contents.
// ---------------------------------------------------------------------------
module tb_daq_frame_serializer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic [2:0]  os_sel_i;
    logic        sample_valid_i;
    logic        sample_first_i;
    logic [15:0] sample_data_i;
    logic        fifo_wrfull_i;
    logic        fifo_wrreq_o;
    logic [7:0]  fifo_data_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        resync_o;
    logic [7:0]  drop_cnt_o;

    always #5 clk_i = ~clk_i;

    daq_frame_serializer #(.ADCCOUNT(8)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .en_i           (en_i),
        .os_sel_i       (os_sel_i),
        .sample_valid_i (sample_valid_i),
        .sample_first_i (sample_first_i),
        .sample_data_i  (sample_data_i),
        .fifo_wrfull_i  (fifo_wrfull_i),
        .fifo_wrreq_o   (fifo_wrreq_o),
        .fifo_data_o    (fifo_data_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .resync_o       (resync_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] byte_q[$];
    int         done_cnt = 0;
    int         resync_cnt = 0;
    int         full_wr = 0;
    int         run = 0;
    int         last_run = 0;

    // FIFO-side monitor
    always @(negedge clk_i) begin
        if (fifo_wrreq_o === 1'b1) begin
            byte_q.push_back(fifo_data_o);
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        if (frame_done_o === 1'b1) done_cnt++;
        if (resync_o === 1'b1) resync_cnt++;
        if (fifo_wrreq_o === 1'b1 && fifo_wrfull_i === 1'b1) full_wr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_word(input logic [15:0] d, input logic f);
        sample_valid_i = 1'b1;
        sample_first_i = f;
        sample_data_i  = d;
        @(posedge clk_i); #1;
        sample_valid_i = 1'b0;
        sample_first_i = 1'b0;
    endtask

    // Returns 1ns after the completion edge.
    task automatic burst(input logic [15:0] base);
        for (int i = 0; i < 8; i++) drive_word(base + 16'(i), i == 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] seq,
                                input logic [2:0] os, input logic [15:0] base);
        logic [7:0]  exp_b[21];
        logic [7:0]  sum;
        logic [15:0] w;
        logic [7:0]  obs;
        int          t;
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'h5A;
        exp_b[2] = seq;
        exp_b[3] = {5'b0, os};
        for (int i = 0; i < 8; i++) begin
            w = base + 16'(i);
            exp_b[4 + 2*i] = w[15:8];
            exp_b[5 + 2*i] = w[7:0];
        end
        sum = 8'h00;
        for (int i = 2; i < 20; i++) sum = sum + exp_b[i];
        exp_b[20] = sum;
        t = 0;
        while (byte_q.size() < 21 && t < 300) begin
            @(negedge clk_i);
            t++;
        end
        #1;
        chk($sformatf("%s_complete", tag), 32'(byte_q.size() >= 21), 32'd1);
        for (int i = 0; i < 21; i++) begin
            obs = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hxx;
            chk($sformatf("%s_b%0d", tag, i), 32'(obs), 32'(exp_b[i]));
        end
    endtask

    initial begin
        reset_i        = 1'b1;
        en_i           = 1'b1;
        os_sel_i       = 3'd0;
        sample_valid_i = 1'b0;
        sample_first_i = 1'b0;
        sample_data_i  = 16'h0000;
        fifo_wrfull_i  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_wrreq", 32'(fifo_wrreq_o), 32'd0);
        chk("rst_data",  32'(fifo_data_o),  32'h00);
        chk("rst_busy",  32'(busy_o),       32'd0);
        chk("rst_done",  32'(frame_done_o), 32'd0);
        chk("rst_resync",32'(resync_o),     32'd0);
        chk("rst_drop",  32'(drop_cnt_o),   32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;

        // 1: basic frame, FIFO never full
        burst(16'h0100);
        @(negedge clk_i);
        chk("t1_hdr0_next", 32'(fifo_data_o),  32'hA5);
        chk("t1_wr_next",   32'(fifo_wrreq_o), 32'd1);
        expect_frame("t1", 8'h00, 3'd0, 16'h0100);
        wait_cycles(2);
        chk("t1_run",      32'(last_run),     32'd21);
        chk("t1_done_cnt", 32'(done_cnt),     32'd1);
        chk("t1_idle",     32'(busy_o),       32'd0);
        chk("t1_idle_data",32'(fifo_data_o),  32'h00);

        // 2: full for 5 cycles while byte 6 (word 1 high = 01) is presented
        burst(16'h0100);
        wait_cycles(6);
        fifo_wrfull_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk($sformatf("t2_nowr%0d", i),  32'(fifo_wrreq_o), 32'd0);
            chk($sformatf("t2_hold%0d", i),  32'(fifo_data_o),  32'h01);
            @(posedge clk_i); #1;
        end
        fifo_wrfull_i = 1'b0;
        expect_frame("t2", 8'h01, 3'd0, 16'h0100);
        chk("t2_full_wr", 32'(full_wr), 32'd0);

        // 3: second burst completes during DATA -> dropped, seq gap
        do_reset();
        burst(16'h0200);
        burst(16'h0300);
        @(negedge clk_i);
        chk("t3_drop", 32'(drop_cnt_o), 32'd1);
        expect_frame("t3a", 8'h00, 3'd0, 16'h0200);
        wait_cycles(2);
        chk("t3_quiet", 32'(byte_q.size()), 32'd0);
        burst(16'h0400);
        expect_frame("t3b", 8'h02, 3'd0, 16'h0400);

        // 4: second burst completes on the CSUM write edge -> back-to-back
        os_sel_i = 3'd5;
        burst(16'h1000);
        os_sel_i = 3'd3;
        wait_cycles(13);
        burst(16'h2000);
        @(negedge clk_i);
        chk("t4_hdr0", 32'(fifo_data_o), 32'hA5);
        chk("t4_busy", 32'(busy_o),      32'd1);
        chk("t4_drop", 32'(drop_cnt_o),  32'd1);
        expect_frame("t4a", 8'h03, 3'd5, 16'h1000);
        expect_frame("t4b", 8'h04, 3'd3, 16'h2000);
        wait_cycles(2);
        chk("t4_run", 32'(last_run), 32'd42);

        // 5: first word seen at idx=3 restarts the burst
        os_sel_i = 3'd0;
        drive_word(16'h5550, 1'b1);
        drive_word(16'h5551, 1'b0);
        drive_word(16'h5552, 1'b0);
        drive_word(16'h6000, 1'b1);
        @(negedge clk_i);
        chk("t5_resync", 32'(resync_o), 32'd1);
        @(negedge clk_i);
        chk("t5_resync_end", 32'(resync_o), 32'd0);
        for (int i = 1; i < 8; i++) drive_word(16'h6000 + 16'(i), 1'b0);
        expect_frame("t5", 8'h05, 3'd0, 16'h6000);
        chk("t5_resync_cnt", 32'(resync_cnt), 32'd1);

        // 6: reset mid-DATA aborts the frame
        burst(16'h7000);
        wait_cycles(8);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("t6_wrreq", 32'(fifo_wrreq_o), 32'd0);
        chk("t6_data",  32'(fifo_data_o),  32'h00);
        chk("t6_busy",  32'(busy_o),       32'd0);
        chk("t6_drop",  32'(drop_cnt_o),   32'd0);
        chk("t6_partial", 32'(byte_q.size()), 32'd8);
        byte_q.delete();
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        wait_cycles(5);
        chk("t6_quiet", 32'(byte_q.size()), 32'd0);
        burst(16'h0800);
        expect_frame("t6", 8'h00, 3'd0, 16'h0800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
